// File: rtl/speed_plant_if.sv
// Actuator/set-point bus between the cruise controller (master) and the speed plant (slave).
interface speed_plant_if #(
   parameter int W = 8
);
   logic         tormoz;
   logic [2:0]   pashesh;
   logic         set_load;
   logic         set_clear;
   logic [W-1:0] set_speed;
   logic [W-1:0] speed;
   logic         gt;
   logic         eq;
   logic         lt;
   logic         armed;
   logic         upd;

   modport master (
      output tormoz, pashesh, set_load, set_clear, set_speed,
      input  speed, gt, eq, lt, armed, upd
   );

   modport slave (
      input  tormoz, pashesh, set_load, set_clear, set_speed,
      output speed, gt, eq, lt, armed, upd
   );
endinterface

// File: rtl/speed_plant.sv
// Vehicle speed plant: integrates brake/injection into a clamped speed with periodic drag,
// and compares it against an armed cruise target to produce gt/eq/lt.
module speed_plant #(
   parameter int W           = 8,
   parameter int UPD_DIV     = 4,
   parameter int BRAKE_DEC   = 4,
   parameter int DRAG_PERIOD = 2,
   parameter int TOL         = 1,
   parameter int MAX_SPEED   = 200
) (
   input logic         clock,
   input logic         reset_n,
   speed_plant_if.slave bus
);

   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [W-1:0] MAX_W     = W'(MAX_SPEED);
   localparam logic [W+1:0] BRAKE_W   = (W+2)'(BRAKE_DEC);
   localparam logic [W:0]   TOL_W     = (W+1)'(TOL);
   localparam logic [7:0]   DIV_LAST  = 8'(UPD_DIV - 1);
   localparam logic [7:0]   DRAG_LAST = 8'(DRAG_PERIOD - 1);

   state_t       state, state_nx;
   logic [W-1:0] speed_r, target;
   logic [7:0]   div_cnt, drag_cnt;
   logic         fire, drag, upd_r;
   logic [W+1:0] sum;
   logic [W-1:0] clamped;
   logic [W:0]   band_lo, band_hi;
   logic         gt_nx, lt_nx, gt_r, eq_r, lt_r;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.set_load)                          state_nx = ARMED;
      else if (bus.set_clear && state == ARMED)  state_nx = IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          target <= '0;
      else if (bus.set_load) target <= (bus.set_speed > MAX_W) ? MAX_W : bus.set_speed;
   end

   assign fire = (div_cnt == DIV_LAST);
   assign drag = (drag_cnt == DRAG_LAST);

   // Two's-complement in W+2 bits: MSB set means the step went below zero.
   always_comb begin
      sum = {2'b00, speed_r} + {{(W-1){1'b0}}, bus.pashesh}
            - (bus.tormoz ? BRAKE_W : '0) - {{(W+1){1'b0}}, drag};
      if (sum[W+1])                   clamped = '0;
      else if (sum > {2'b00, MAX_W})  clamped = MAX_W;
      else                            clamped = sum[W-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= '0;
         drag_cnt <= '0;
         speed_r  <= '0;
         upd_r    <= 1'b0;
      end else begin
         div_cnt <= fire ? '0 : div_cnt + 8'd1;
         upd_r   <= fire;
         if (fire) begin
            speed_r  <= clamped;
            drag_cnt <= drag ? '0 : drag_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      band_lo = ({1'b0, target} >= TOL_W) ? ({1'b0, target} - TOL_W) : '0;
      band_hi = {1'b0, target} + TOL_W;
      gt_nx   = (state == ARMED) && ({1'b0, speed_r} > band_hi);
      lt_nx   = (state == ARMED) && ({1'b0, speed_r} < band_lo);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         gt_r <= 1'b0;
         eq_r <= 1'b1;
         lt_r <= 1'b0;
      end else begin
         gt_r <= gt_nx;
         eq_r <= !(gt_nx || lt_nx);
         lt_r <= lt_nx;
      end
   end

   assign bus.speed = speed_r;
   assign bus.upd   = upd_r;
   assign bus.armed = (state == ARMED);
   assign bus.gt    = gt_r;
   assign bus.eq    = eq_r;
   assign bus.lt    = lt_r;

endmodule
